// File: rtl/pong_round_sequencer_if.sv
// Bundle of frame timing, round result and gating signals around the pong round sequencer.
// ROUND_PAUSE_EN adds the pause request line.
interface pong_round_sequencer_if;
  logic       screen_end;
  logic       start;
  logic [2:0] winner_in;
`ifdef ROUND_PAUSE_EN
  logic       pause;
`endif
  logic       ball_hold;
  logic       paddles_en;
  logic       frame_tick;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [2:0] seg_value;
  logic       match_over;
  logic [2:0] state;

  // Sequencer side
  modport slave (
`ifdef ROUND_PAUSE_EN
    input  pause,
`endif
    input  screen_end, start, winner_in,
    output ball_hold, paddles_en, frame_tick, p1_score, p2_score, seg_value, match_over, state
  );

  // Environment side (timing generator, processor, paddles, display)
  modport master (
`ifdef ROUND_PAUSE_EN
    output pause,
`endif
    output screen_end, start, winner_in,
    input  ball_hold, paddles_en, frame_tick, p1_score, p2_score, seg_value, match_over, state
  );
endinterface

// File: rtl/pong_round_sequencer.sv
// Frame-synchronous round sequencer for pong: IDLE -> SERVE -> PLAY -> SCORED -> (SERVE|GAMEOVER).
// Keeps both scores, gates ball and paddles, and drives the 7-segment value.
// Optional macro ROUND_PAUSE_EN adds a pause toggle (PAUSED state, encoding 5) from PLAY.
module pong_round_sequencer #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned HOLD_FRAMES  = 90,
  parameter int unsigned WIN_SCORE    = 5,
  parameter int unsigned CNT_W        = 8
) (
  input logic                   clk,
  input logic                   reset,
  pong_round_sequencer_if.slave bus
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_SERVE    = 3'd1;
  localparam logic [2:0] ST_PLAY     = 3'd2;
  localparam logic [2:0] ST_SCORED   = 3'd3;
  localparam logic [2:0] ST_GAMEOVER = 3'd4;
`ifdef ROUND_PAUSE_EN
  localparam logic [2:0] ST_PAUSED   = 3'd5;
`endif

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_FRAMES - 1);
  localparam logic [3:0]       WIN_PTS    = 4'(WIN_SCORE);

  logic             r_armed, r_se_q, r_frame_tick;
  logic [2:0]       r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic [3:0]       r_p1, w_p1_d, r_p2, w_p2_d;
  logic [1:0]       r_scorer, w_scorer_d;
  logic             r_ball_hold, w_ball_hold;
  logic             r_paddles_en, w_paddles_en;
  logic             r_match_over, w_match_over;
  logic [2:0]       r_seg, w_seg;
`ifdef ROUND_PAUSE_EN
  logic             r_pause_q;
  logic             w_pause_rise;

  assign w_pause_rise = bus.pause & ~r_pause_q & r_armed;

  // Pause edge detector history
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_pause_q <= 1'b0;
    else        r_pause_q <= bus.pause;
  end
`endif

  // screen_end edge detect; r_armed suppresses a tick when screen_end is already high at release
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed      <= 1'b0;
      r_se_q       <= 1'b0;
      r_frame_tick <= 1'b0;
    end else begin
      r_armed      <= 1'b1;
      r_se_q       <= bus.screen_end;
      r_frame_tick <= bus.screen_end & ~r_se_q & r_armed;
    end
  end

  // Next-state, frame counter and score logic
  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_p1_d     = r_p1;
    w_p2_d     = r_p2;
    w_scorer_d = r_scorer;
    case (r_state)
      ST_IDLE, ST_GAMEOVER: begin
        if (bus.start) begin
          w_state_d = ST_SERVE;
          w_cnt_d   = '0;
          w_p1_d    = 4'd0;
          w_p2_d    = 4'd0;
        end
      end
      ST_SERVE: begin
        if (r_frame_tick) begin
          if (r_cnt == SERVE_LAST) begin
            w_state_d = ST_PLAY;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      ST_PLAY: begin
`ifdef ROUND_PAUSE_EN
        if (w_pause_rise) w_state_d = ST_PAUSED;
        else
`endif
        if (r_frame_tick && (bus.winner_in == 3'd1 || bus.winner_in == 3'd2)) begin
          w_state_d = ST_SCORED;
          w_cnt_d   = '0;
          if (bus.winner_in == 3'd1) begin
            w_scorer_d = 2'd1;
            if (r_p1 < WIN_PTS) w_p1_d = r_p1 + 4'd1;
          end else begin
            w_scorer_d = 2'd2;
            if (r_p2 < WIN_PTS) w_p2_d = r_p2 + 4'd1;
          end
        end
      end
      ST_SCORED: begin
        if (r_frame_tick) begin
          if (r_cnt == HOLD_LAST) begin
            w_cnt_d   = '0;
            w_state_d = (r_p1 >= WIN_PTS || r_p2 >= WIN_PTS) ? ST_GAMEOVER : ST_SERVE;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
`ifdef ROUND_PAUSE_EN
      ST_PAUSED: begin
        if (w_pause_rise) w_state_d = ST_PLAY;
      end
`endif
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Output decode from the next state so outputs move on the same edge as the state
  always_comb begin
    w_ball_hold  = 1'b1;
    w_paddles_en = 1'b0;
    w_match_over = 1'b0;
    w_seg        = 3'd0;
    case (w_state_d)
      ST_SERVE:    w_paddles_en = 1'b1;
      ST_PLAY: begin
        w_ball_hold  = 1'b0;
        w_paddles_en = 1'b1;
      end
      ST_SCORED:   w_seg = {1'b0, w_scorer_d};
      // The last scorer is always the one who reached WIN_SCORE
      ST_GAMEOVER: begin
        w_match_over = 1'b1;
        w_seg        = {1'b0, w_scorer_d};
      end
      default: ;
    endcase
  end

  // State, counter, scores and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_p1         <= 4'd0;
      r_p2         <= 4'd0;
      r_scorer     <= 2'd0;
      r_ball_hold  <= 1'b1;
      r_paddles_en <= 1'b0;
      r_match_over <= 1'b0;
      r_seg        <= 3'd0;
    end else begin
      r_state      <= w_state_d;
      r_cnt        <= w_cnt_d;
      r_p1         <= w_p1_d;
      r_p2         <= w_p2_d;
      r_scorer     <= w_scorer_d;
      r_ball_hold  <= w_ball_hold;
      r_paddles_en <= w_paddles_en;
      r_match_over <= w_match_over;
      r_seg        <= w_seg;
    end
  end

  assign bus.ball_hold  = r_ball_hold;
  assign bus.paddles_en = r_paddles_en;
  assign bus.frame_tick = r_frame_tick;
  assign bus.p1_score   = r_p1;
  assign bus.p2_score   = r_p2;
  assign bus.seg_value  = r_seg;
  assign bus.match_over = r_match_over;
  assign bus.state      = r_state;

endmodule

// File: tb/tb_pong_round_sequencer.sv
// Directed self-checking bench for pong_round_sequencer (SERVE_FRAMES=3, HOLD_FRAMES=2, WIN_SCORE=2).
module tb_pong_round_sequencer;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_pass = 0;

  pong_round_sequencer_if bus ();

  pong_round_sequencer #(
    .SERVE_FRAMES(3),
    .HOLD_FRAMES (2),
    .WIN_SCORE   (2),
    .CNT_W       (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // Advance n clocks, leaving time 1 unit past the last rising edge
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One frame: screen_end rises, one tick pulse, FSM reacts on the following edge
  task automatic frame();
    bus.screen_end = 1'b1;
    cyc(1);
    check("frame_tick_rise", bus.frame_tick, 1);
    cyc(1);
    check("frame_tick_single", bus.frame_tick, 0);
    bus.screen_end = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cyc(1);
    bus.start = 1'b0;
  endtask

  initial begin
    bus.screen_end = 1'b0;
    bus.start      = 1'b0;
    bus.winner_in  = 3'd0;
`ifdef ROUND_PAUSE_EN
    bus.pause      = 1'b0;
`endif
    // Reset held while screen_end toggles
    for (int i = 0; i < 4; i++) begin
      bus.screen_end = ~bus.screen_end;
      cyc(1);
      check("rst_tick", bus.frame_tick, 0);
    end
    check("rst_state", bus.state, 0);
    check("rst_ball_hold", bus.ball_hold, 1);
    check("rst_paddles", bus.paddles_en, 0);
    check("rst_p1", bus.p1_score, 0);
    check("rst_p2", bus.p2_score, 0);
    check("rst_seg", bus.seg_value, 0);
    check("rst_match_over", bus.match_over, 0);

    // Release with screen_end already high: no tick
    bus.screen_end = 1'b1;
    cyc(1);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      check("release_no_tick", bus.frame_tick, 0);
    end
    bus.screen_end = 1'b0;
    cyc(2);
    check("idle_state", bus.state, 0);

    // Start -> SERVE
    pulse_start();
    check("serve_state", bus.state, 1);
    check("serve_hold", bus.ball_hold, 1);
    check("serve_paddles", bus.paddles_en, 1);

    // Serve timing: PLAY one clk after the 3rd tick
    frame();
    frame();
    check("serve_after2", bus.state, 1);
    bus.screen_end = 1'b1;
    cyc(1);
    check("tick3", bus.frame_tick, 1);
    check("tick3_state", bus.state, 1);
    check("tick3_hold", bus.ball_hold, 1);
    cyc(1);
    check("play_state", bus.state, 2);
    check("play_hold", bus.ball_hold, 0);
    check("play_paddles", bus.paddles_en, 1);
    bus.screen_end = 1'b0;
    cyc(2);

    // start ignored in PLAY
    pulse_start();
    check("start_ign_play", bus.state, 2);

    // winner_in=3 ignored, winner_in=1 scores
    bus.winner_in = 3'd3;
    frame();
    check("w3_state", bus.state, 2);
    check("w3_p1", bus.p1_score, 0);
    check("w3_p2", bus.p2_score, 0);
    bus.winner_in = 3'd1;
    frame();
    check("p1_sc_state", bus.state, 3);
    check("p1_sc_p1", bus.p1_score, 1);
    check("p1_sc_seg", bus.seg_value, 1);
    check("p1_sc_hold", bus.ball_hold, 1);
    check("p1_sc_paddles", bus.paddles_en, 0);
    frame();
    check("scored_hold1", bus.state, 3);
    check("scored_ign_p1", bus.p1_score, 1);
    frame();
    check("back_serve", bus.state, 1);
    check("back_serve_p1", bus.p1_score, 1);
    check("back_serve_seg", bus.seg_value, 0);
    bus.winner_in = 3'd0;

    // P2 scores twice -> GAMEOVER
    for (int r = 0; r < 2; r++) begin
      repeat (3) frame();
      check("p2_play", bus.state, 2);
      bus.winner_in = 3'd2;
      frame();
      bus.winner_in = 3'd0;
      check("p2_scored", bus.state, 3);
      check("p2_seg", bus.seg_value, 2);
      check("p2_pts", bus.p2_score, r + 1);
      repeat (2) frame();
    end
    check("go_state", bus.state, 4);
    check("go_match_over", bus.match_over, 1);
    check("go_seg", bus.seg_value, 2);
    check("go_p1", bus.p1_score, 1);
    check("go_p2", bus.p2_score, 2);
    check("go_hold", bus.ball_hold, 1);
    pulse_start();
    check("restart_state", bus.state, 1);
    check("restart_p1", bus.p1_score, 0);
    check("restart_p2", bus.p2_score, 0);
    check("restart_match_over", bus.match_over, 0);
    check("restart_seg", bus.seg_value, 0);

    // Score once then reach PLAY with p1=1, then async reset between edges
    repeat (3) frame();
    bus.winner_in = 3'd1;
    frame();
    bus.winner_in = 3'd0;
    repeat (2) frame();
    repeat (3) frame();
    check("pre_rst_state", bus.state, 2);
    check("pre_rst_p1", bus.p1_score, 1);
    #2;
    reset = 1'b0;
    #1;
    check("arst_state", bus.state, 0);
    check("arst_hold", bus.ball_hold, 1);
    check("arst_paddles", bus.paddles_en, 0);
    check("arst_p1", bus.p1_score, 0);
    cyc(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
